// File: rtl/avalon_burst_register_adapter.sv
// Avalon-MM burst slave bridging to a flat peripheral register bank.
// Bursts use incrementing word addresses. Beats at addresses >= REGS produce no strobe.
// An out-of-range read beat returns SLVERR.
module avalon_burst_register_adapter #(
    parameter int unsigned BUSWIDTH     = 32,
    parameter int unsigned REGS         = 8,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned MAXBURST     = 4,
    parameter int unsigned BURSTWIDTH   = $clog2(MAXBURST) + 1,
    parameter int unsigned ADDRESSWIDTH = $clog2(REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDRESSWIDTH-1:0]    address,
    input  logic [BURSTWIDTH-1:0]      burstcount,
    input  logic [BUSWIDTH/8-1:0]      byteenable,
    input  logic [BUSWIDTH-1:0]        data_in,
    output logic                       waitrequest,
    output logic                       read_valid,
    output logic [BUSWIDTH-1:0]        data_out,
    output logic [1:0]                 response,
    output logic [REGS-1:0]            reg_write_en,
    output logic [REGS-1:0]            reg_read_en,
    output logic [BUSWIDTH/8-1:0]      reg_byteenable,
    output logic [BUSWIDTH-1:0]        reg_data_in,
    input  logic [REGS*BUSWIDTH-1:0]   reg_data_out
);

    localparam int unsigned BYTES = BUSWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2
    } state_t;

    // One extra address bit so a burst running past the last register
    // stays out of range instead of wrapping back onto register 0.
    typedef logic [ADDRESSWIDTH:0] baddr_t;

    typedef struct packed {
        logic                valid;
        logic                is_write;
        baddr_t              addr;
        logic [BUSWIDTH-1:0] data;
        logic [BYTES-1:0]    be;
    } beat_t;

    state_t                state, state_next;
    baddr_t                beat_addr, beat_addr_next, addr_inc;
    logic [BURSTWIDTH-1:0] remaining, remaining_next, burst_len;
    beat_t                 issue, strobe;
    logic                  in_range;
    logic [BUSWIDTH-1:0]   rdata;

    // Normalise the requested length: 0 means 1, oversize clamps to MAXBURST.
    always_comb begin
        burst_len = burstcount;
        if (burstcount == '0) begin
            burst_len = BURSTWIDTH'(1);
        end else if (burstcount > BURSTWIDTH'(MAXBURST)) begin
            burst_len = BURSTWIDTH'(MAXBURST);
        end
    end

    // Saturating increment keeps an overrunning burst out of range.
    assign addr_inc = (beat_addr == '1) ? beat_addr : beat_addr + baddr_t'(1);

    // Burst FSM: next state, waitrequest and the beat issued this cycle.
    always_comb begin
        state_next     = state;
        beat_addr_next = beat_addr;
        remaining_next = remaining;
        waitrequest    = 1'b0;
        issue          = '0;
        unique case (state)
            IDLE: begin
                if (read || write) begin
                    issue.valid    = 1'b1;
                    issue.is_write = write;
                    issue.addr     = {1'b0, address};
                    issue.data     = data_in;
                    issue.be       = byteenable;
                    if (burst_len > BURSTWIDTH'(1)) begin
                        state_next     = write ? WBURST : RBURST;
                        beat_addr_next = {1'b0, address} + baddr_t'(1);
                        remaining_next = burst_len - BURSTWIDTH'(1);
                    end
                end
            end
            RBURST: begin
                waitrequest    = 1'b1;
                issue.valid    = 1'b1;
                issue.addr     = beat_addr;
                beat_addr_next = addr_inc;
                remaining_next = remaining - BURSTWIDTH'(1);
                if (remaining == BURSTWIDTH'(1)) begin
                    state_next = IDLE;
                end
            end
            WBURST: begin
                waitrequest = read;
                if (write) begin
                    issue.valid    = 1'b1;
                    issue.is_write = 1'b1;
                    issue.addr     = beat_addr;
                    issue.data     = data_in;
                    issue.be       = byteenable;
                    beat_addr_next = addr_inc;
                    remaining_next = remaining - BURSTWIDTH'(1);
                    if (remaining == BURSTWIDTH'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // With LATENCY=1 the strobes are combinational, so suppress them in reset.
        if (!reset_n) begin
            issue.valid = 1'b0;
        end
    end

    // FSM state and burst bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            beat_addr <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            beat_addr <= beat_addr_next;
            remaining <= remaining_next;
        end
    end

    generate
        if (LATENCY == 1) begin : g_comb
            assign strobe = issue;
        end else begin : g_pipe
            beat_t shift_q [LATENCY-1];

            // Delay line carrying issued beats to the strobe cycle.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                        shift_q[i] <= '0;
                    end
                end else begin
                    shift_q[0] <= issue;
                    for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                        shift_q[i] <= shift_q[i-1];
                    end
                end
            end

            assign strobe = shift_q[LATENCY-2];
        end
    endgenerate

    assign in_range       = strobe.addr < baddr_t'(REGS);
    assign reg_data_in    = strobe.data;
    assign reg_byteenable = strobe.be;

    // Decode the strobe beat into one-hot register strobes and select read data.
    always_comb begin
        reg_write_en = '0;
        reg_read_en  = '0;
        rdata        = '0;
        for (int unsigned i = 0; i < REGS; i++) begin
            if (strobe.addr == baddr_t'(i)) begin
                rdata = reg_data_out[i*BUSWIDTH +: BUSWIDTH];
                if (strobe.valid) begin
                    if (strobe.is_write) begin
                        reg_write_en[i] = 1'b1;
                    end else begin
                        reg_read_en[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Read return: one registered pulse per read beat; data_out holds between beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_valid <= 1'b0;
            data_out   <= '0;
            response   <= 2'b00;
        end else begin
            read_valid <= strobe.valid && !strobe.is_write;
            if (strobe.valid && !strobe.is_write) begin
                data_out <= in_range ? rdata : '0;
                response <= in_range ? 2'b00 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_avalon_burst_register_adapter.sv
// Bench for avalon_burst_register_adapter: LATENCY=1 and LATENCY=3 instances share stimulus.
// The reference model tracks bursts as beat counts and a per-cycle history of issued beats.
module tb_avalon_burst_register_adapter;

    localparam int NR  = 8;
    localparam int MB  = 4;
    localparam int AW  = 3;
    localparam int BCW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n, read, write;
    logic [AW-1:0]  address;
    logic [BCW-1:0] burstcount;
    logic [3:0]     byteenable;
    logic [31:0]    data_in;
    logic [31:0]    regs [NR];
    logic [NR*32-1:0] reg_data_out;

    logic        wait1, rv1, wait3, rv3;
    logic [31:0] dout1, rdin1, dout3, rdin3;
    logic [1:0]  resp1, resp3;
    logic [7:0]  wren1, rden1, wren3, rden3;
    logic [3:0]  rbe1, rbe3;

    // Static peripheral: register contents come from the bench array.
    always_comb begin
        reg_data_out = '0;
        for (int i = 0; i < NR; i++) reg_data_out[i*32 +: 32] = regs[i];
    end

    avalon_burst_register_adapter #(
        .BUSWIDTH(32), .REGS(NR), .LATENCY(1), .MAXBURST(MB)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write),
        .address(address), .burstcount(burstcount), .byteenable(byteenable),
        .data_in(data_in), .waitrequest(wait1), .read_valid(rv1), .data_out(dout1),
        .response(resp1), .reg_write_en(wren1), .reg_read_en(rden1),
        .reg_byteenable(rbe1), .reg_data_in(rdin1), .reg_data_out(reg_data_out)
    );

    avalon_burst_register_adapter #(
        .BUSWIDTH(32), .REGS(NR), .LATENCY(3), .MAXBURST(MB)
    ) u_dut3 (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write),
        .address(address), .burstcount(burstcount), .byteenable(byteenable),
        .data_in(data_in), .waitrequest(wait3), .read_valid(rv3), .data_out(dout3),
        .response(resp3), .reg_write_en(wren3), .reg_read_en(rden3),
        .reg_byteenable(rbe3), .reg_data_in(rdin3), .reg_data_out(reg_data_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int          m_rd_left, m_wr_left, m_next;
    bit          h_v [4];
    bit          h_w [4];
    int          h_a [4];
    logic [31:0] h_d [4];
    logic [3:0]  h_be [4];
    logic        e_rv [2];
    logic [31:0] e_dout [2];
    logic [1:0]  e_resp [2];

    // Observations of the most recent cycle (index 0: LATENCY=1, 1: LATENCY=3)
    logic        o_wait;
    logic        o_rv [2];
    logic [31:0] o_dout [2];
    logic [1:0]  o_resp [2];
    logic [7:0]  o_rden [2];
    logic [7:0]  o_wren [2];
    logic [3:0]  o_be [2];
    logic [31:0] o_rdin [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit   iv, iw;
        int   a, len, slot, lat;
        logic exp_wait;
        logic [7:0] er, ew;
        iv = 0; iw = 0; a = 0; exp_wait = 1'b0;
        if (!reset_n) begin
            m_rd_left = 0; m_wr_left = 0;
            for (int i = 0; i < 4; i++) h_v[i] = 0;
            for (int k = 0; k < 2; k++) begin
                e_rv[k] = 1'b0; e_dout[k] = '0; e_resp[k] = 2'b00;
            end
        end else begin
            exp_wait = (m_rd_left > 0) ? 1'b1 : (m_wr_left > 0) ? read : 1'b0;
            if (m_rd_left > 0) begin
                iv = 1; a = m_next; m_next++; m_rd_left--;
            end else if (m_wr_left > 0) begin
                if (write) begin
                    iv = 1; iw = 1; a = m_next; m_next++; m_wr_left--;
                end
            end else if (read || write) begin
                len = (burstcount == 0) ? 1 : (int'(burstcount) > MB) ? MB : int'(burstcount);
                iv = 1; iw = write; a = int'(address); m_next = a + 1;
                if (write) m_wr_left = len - 1;
                else       m_rd_left = len - 1;
            end
            slot = cyc & 3;
            h_v[slot] = iv; h_w[slot] = iw; h_a[slot] = a;
            h_d[slot] = data_in; h_be[slot] = byteenable;
        end
        check("waitrequest_l1", 32'(o_wait), 32'(exp_wait));
        check("waitrequest_l3", 32'(wait3), 32'(exp_wait));
        for (int k = 0; k < 2; k++) begin
            lat  = (k == 0) ? 1 : 3;
            slot = (cyc - (lat - 1)) & 3;
            er = (h_v[slot] && !h_w[slot] && h_a[slot] < NR) ? 8'(1 << h_a[slot]) : 8'h00;
            ew = (h_v[slot] &&  h_w[slot] && h_a[slot] < NR) ? 8'(1 << h_a[slot]) : 8'h00;
            check("model_reg_read_en", 32'(o_rden[k]), 32'(er));
            check("model_reg_write_en", 32'(o_wren[k]), 32'(ew));
            if (ew != 8'h00) begin
                check("model_reg_byteenable", 32'(o_be[k]), 32'(h_be[slot]));
                check("model_reg_data_in", o_rdin[k], h_d[slot]);
            end
            check("model_read_valid", 32'(o_rv[k]), 32'(e_rv[k]));
            check("model_data_out", o_dout[k], e_dout[k]);
            check("model_response", 32'(o_resp[k]), 32'(e_resp[k]));
            if (h_v[slot] && !h_w[slot]) begin
                e_rv[k] = 1'b1;
                if (h_a[slot] < NR) begin
                    e_dout[k] = regs[h_a[slot]]; e_resp[k] = 2'b00;
                end else begin
                    e_dout[k] = '0; e_resp[k] = 2'b10;
                end
            end else begin
                e_rv[k] = 1'b0;
            end
        end
        cyc++;
    endtask

    // One clock cycle: observe at the falling edge, run the model, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        o_wait = wait1;
        o_rv[0] = rv1; o_dout[0] = dout1; o_resp[0] = resp1;
        o_rden[0] = rden1; o_wren[0] = wren1; o_be[0] = rbe1; o_rdin[0] = rdin1;
        o_rv[1] = rv3; o_dout[1] = dout3; o_resp[1] = resp3;
        o_rden[1] = rden3; o_wren[1] = wren3; o_be[1] = rbe3; o_rdin[1] = rdin3;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read = 1'b0; write = 1'b0; address = '0; burstcount = '0;
        byteenable = '0; data_in = '0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [2:0]  addr, bc;
        logic [3:0]  be;
        logic [31:0] din;
        logic [7:0]  exp_rden, exp_wren;
        logic        exp_rv;
        logic [31:0] exp_dout;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 3'd5, 3'd1, 4'hF, 32'h0,        8'h20, 8'h00, 1'b1, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{1'b1, 1'b0, 3'd0, 3'd0, 4'hF, 32'h0,        8'h01, 8'h00, 1'b1, 32'h00000100, 2'b00};
        vecs[2] = '{1'b0, 1'b1, 3'd3, 3'd1, 4'h3, 32'h12345678, 8'h00, 8'h08, 1'b0, 32'h00000100, 2'b00};
        vecs[3] = '{1'b1, 1'b1, 3'd7, 3'd1, 4'hF, 32'hCAFEF00D, 8'h00, 8'h80, 1'b0, 32'h00000100, 2'b00};
        vecs[4] = '{1'b1, 1'b0, 3'd7, 3'd1, 4'h0, 32'h0,        8'h80, 8'h00, 1'b1, 32'h00000107, 2'b00};
        vecs[5] = '{1'b0, 1'b1, 3'd0, 3'd0, 4'h1, 32'h55AA55AA, 8'h00, 8'h01, 1'b0, 32'h00000107, 2'b00};

        m_rd_left = 0; m_wr_left = 0; m_next = 0;
        for (int i = 0; i < 4; i++) begin
            h_v[i] = 0; h_w[i] = 0; h_a[i] = 0; h_d[i] = '0; h_be[i] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = 1'b0; e_dout[k] = '0; e_resp[k] = 2'b00;
        end
        for (int i = 0; i < NR; i++) regs[i] = 32'h100 + 32'(i);
        regs[5] = 32'hDEADBEEF;
        reset_n = 1'b0;
        idle();

        // Reset state
        tick();
        check("reset_waitrequest", 32'(o_wait), 32'h0);
        check("reset_read_valid", 32'(o_rv[0]), 32'h0);
        check("reset_data_out", o_dout[0], 32'h0);
        check("reset_response", 32'(o_resp[0]), 32'h0);
        check("reset_strobes", 32'({o_rden[0], o_wren[0]}), 32'h0);
        tick();
        reset_n = 1'b1;

        // Single-beat vectors on the LATENCY=1 instance
        for (int i = 0; i < 6; i++) begin
            read = vecs[i].rd; write = vecs[i].wr; address = vecs[i].addr;
            burstcount = vecs[i].bc; byteenable = vecs[i].be; data_in = vecs[i].din;
            tick();
            check("vec_reg_read_en", 32'(o_rden[0]), 32'(vecs[i].exp_rden));
            check("vec_reg_write_en", 32'(o_wren[0]), 32'(vecs[i].exp_wren));
            idle();
            tick();
            check("vec_read_valid", 32'(o_rv[0]), 32'(vecs[i].exp_rv));
            check("vec_data_out", o_dout[0], vecs[i].exp_dout);
            check("vec_response", 32'(o_resp[0]), 32'(vecs[i].exp_resp));
        end
        regs[5] = 32'h105;
        tick(); tick();

        // Read burst at 2, length 4: three stalled cycles, four consecutive returns
        read = 1'b1; address = 3'd2; burstcount = 3'd4;
        tick();
        check("rb_first_wait", 32'(o_wait), 32'h0);
        check("rb_first_rden", 32'(o_rden[0]), 32'h04);
        idle();
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rb_wait", 32'(o_wait), (k <= 3) ? 32'h1 : 32'h0);
            check("rb_read_valid", 32'(o_rv[0]), (k <= 4) ? 32'h1 : 32'h0);
            if (k <= 4) begin
                check("rb_data", o_dout[0], 32'h101 + 32'(k));
                check("rb_resp", 32'(o_resp[0]), 32'h0);
            end
        end

        // Read burst at 6, length 4: runs off the end of the register bank
        read = 1'b1; address = 3'd6; burstcount = 3'd4;
        tick();
        check("oor_rden0", 32'(o_rden[0]), 32'h40);
        idle();
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("oor_rden", 32'(o_rden[0]), (k == 1) ? 32'h80 : 32'h0);
            check("oor_read_valid", 32'(o_rv[0]), (k <= 4) ? 32'h1 : 32'h0);
            if (k <= 4) begin
                check("oor_data", o_dout[0], (k == 1) ? 32'h106 : (k == 2) ? 32'h107 : 32'h0);
                check("oor_resp", 32'(o_resp[0]), (k <= 2) ? 32'h0 : 32'h2);
            end
        end

        // Write burst at 1, length 3, idle gap between beats 1 and 2
        write = 1'b1; address = 3'd1; burstcount = 3'd3; byteenable = 4'h3; data_in = 32'hAAAA0001;
        tick();
        check("wb_wren0", 32'(o_wren[0]), 32'h02);
        check("wb_be0", 32'(o_be[0]), 32'h3);
        check("wb_wait0", 32'(o_wait), 32'h0);
        address = 3'd0; burstcount = 3'd0; data_in = 32'hAAAA0002;
        tick();
        check("wb_wren1", 32'(o_wren[0]), 32'h04);
        check("wb_be1", 32'(o_be[0]), 32'h3);
        check("wb_data1", o_rdin[0], 32'hAAAA0002);
        check("wb_wait1", 32'(o_wait), 32'h0);
        write = 1'b0;
        tick();
        check("wb_gap_wren", 32'(o_wren[0]), 32'h0);
        check("wb_gap_wait", 32'(o_wait), 32'h0);
        write = 1'b1; data_in = 32'hAAAA0003;
        tick();
        check("wb_wren2", 32'(o_wren[0]), 32'h08);
        check("wb_be2", 32'(o_be[0]), 32'h3);
        check("wb_wait2", 32'(o_wait), 32'h0);
        idle();
        tick(); tick(); tick();

        // LATENCY=3: back-to-back single reads at 0, 1, 2
        for (int k = 0; k <= 6; k++) begin
            if (k < 3) begin
                read = 1'b1; address = 3'(k); burstcount = 3'd1;
            end else begin
                idle();
            end
            tick();
            check("l3_rden", 32'(o_rden[1]), (k >= 2 && k <= 4) ? 32'(1 << (k - 2)) : 32'h0);
            check("l3_read_valid", 32'(o_rv[1]), (k >= 3 && k <= 5) ? 32'h1 : 32'h0);
            if (k >= 3 && k <= 5) check("l3_data", o_dout[1], 32'h100 + 32'(k - 3));
        end

        // Reset during the second beat of a 4-beat read burst
        read = 1'b1; address = 3'd0; burstcount = 3'd4;
        tick();
        idle();
        reset_n = 1'b0;
        tick();
        check("rst_read_valid", 32'(o_rv[0]), 32'h0);
        check("rst_data_out", o_dout[0], 32'h0);
        check("rst_rden", 32'(o_rden[0]), 32'h0);
        check("rst_wait", 32'(o_wait), 32'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_rv_l1", 32'(o_rv[0]), 32'h0);
            check("post_rst_rv_l3", 32'(o_rv[1]), 32'h0);
            check("post_rst_rden", 32'({o_rden[0], o_rden[1]}), 32'h0);
        end
        read = 1'b1; address = 3'd0; burstcount = 3'd0;
        tick();
        check("post_rst_read_rden", 32'(o_rden[0]), 32'h01);
        idle();
        tick();
        check("post_rst_read_rv", 32'(o_rv[0]), 32'h1);
        check("post_rst_read_data", o_dout[0], 32'h100);
        tick();
        check("bc0_single_beat_rv", 32'(o_rv[0]), 32'h0);
        check("bc0_single_beat_wait", 32'(o_wait), 32'h0);
        tick(); tick();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset_n    = ($urandom_range(0, 99) != 0);
            read       = ($urandom_range(0, 2) == 0);
            write      = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            burstcount = 3'($urandom_range(0, 7));
            byteenable = 4'($urandom);
            data_in    = $urandom;
            if ($urandom_range(0, 9) == 0) regs[$urandom_range(0, NR - 1)] = $urandom;
            tick();
        end
        reset_n = 1'b1;
        idle();
        for (int k = 0; k < 8; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_burst_register_adapter.md
Name: avalon_burst_register_adapter

Overview:
Avalon-MM slave to peripheral register-file bridge, next generation of the single-beat register adapter. Adds fixed-increment read/write bursts, byte enables, waitrequest flow control and an error response for out-of-range addresses, with a configurable strobe pipeline depth. Sits between the system interconnect and a peripheral's flat register bank.

Parameters:
BUSWIDTH, 32, data width in bits; multiple of 8
REGS, 8, number of peripheral registers; 2 or more
LATENCY, 1, cycles from beat issue to read_valid; 1 or more
MAXBURST, 4, largest supported burst length; 1 or more
BURSTWIDTH, $clog2(MAXBURST)+1, burstcount width
ADDRESSWIDTH, $clog2(REGS), word address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
read  in  1  Avalon read request
write  in  1  Avalon write request
address  in  ADDRESSWIDTH  word address of the first beat
burstcount  in  BURSTWIDTH  beats in the burst
byteenable  in  BUSWIDTH/8  byte lanes for writes
data_in  in  BUSWIDTH  write data
waitrequest  out  1  command stall
read_valid  out  1  read beat valid
data_out  out  BUSWIDTH  read beat data
response  out  2  00 OKAY, 10 SLVERR; valid with read_valid
reg_write_en  out  REGS  one-hot write strobe
reg_read_en  out  REGS  one-hot read strobe
reg_byteenable  out  BUSWIDTH/8  byte lanes for reg_write_en
reg_data_in  out  BUSWIDTH  write data to registers
reg_data_out  in  REGS*BUSWIDTH  flat register contents; register i at [i*BUSWIDTH +: BUSWIDTH]

Behaviour:
- Single clock domain, clk.
- reset_n is asynchronous and active-low. While it is low: FSM returns to IDLE, burst counter and every pipeline stage clear.
- Reset values: waitrequest 0, read_valid 0, data_out 0, response 00. No strobes during reset.
- Command acceptance: accepted when (read | write) & !waitrequest.
  - read and write asserted together: treated as a write; the read is ignored.
  - burstcount 0 is treated as 1; burstcount above MAXBURST is clamped to MAXBURST.
- Beat address: internal counter is ADDRESSWIDTH+1 bits and does not wrap. Beat k targets address+k.
- Out-of-range beat (beat address >= REGS):
  - No strobe is generated.
  - A read beat returns data 0 with response 10.
  - A write beat is silently dropped.
- FSM states: IDLE, RBURST, WBURST.
- IDLE:
  - An accepted read issues beat 0 in the same cycle. If burstcount > 1, go to RBURST with remaining = burstcount-1.
  - An accepted write issues beat 0. If burstcount > 1, go to WBURST with remaining = burstcount-1.
- RBURST:
  - waitrequest = 1.
  - Issues one beat per cycle with no master involvement.
  - Returns to IDLE in the cycle after the last beat is issued.
- WBURST:
  - waitrequest = read; a write is never stalled.
  - Each write cycle issues the next beat with the current data_in and byteenable.
  - Idle cycles (write low) issue nothing.
  - Returns to IDLE after the last beat.
- Pipeline timing:
  - A beat issued in cycle t drives reg_write_en/reg_read_en, reg_data_in and reg_byteenable during cycle t+LATENCY-1. With LATENCY=1 these are combinational from the Avalon inputs in cycle t.
  - read_valid, data_out and response are registered and appear in cycle t+LATENCY.
  - Full throughput: one beat per cycle, and read_valid can be high on consecutive cycles.
- Read data: captured from the selected reg_data_out slice in the strobe cycle. Read side effects in the peripheral are triggered by reg_read_en only.
- read_valid has no backpressure. Every issued read beat, including out-of-range beats, produces exactly one read_valid pulse, in order.
- data_out holds its last value when read_valid is 0.
- Reset mid-burst: the burst is abandoned. No further strobes or read_valid pulses occur; the next command after reset release starts in IDLE.

Test Plan:
- LATENCY=1, REGS=8, reg 5 = 0xDEADBEEF; single read at address 5 -> reg_read_en = 0x20 in the same cycle; next cycle read_valid=1, data_out=0xDEADBEEF, response=00.
- Read burst at address 2, burstcount 4 (registers i = 0x100+i) -> waitrequest high for 3 cycles; read_valid on 4 consecutive cycles with data 0x102..0x105, all response 00.
- Read burst at address 6, burstcount 4, REGS=8 -> beats 0x106 and 0x107 with OKAY, then two beats of data 0 with response 10; reg_read_en never addresses beyond bit 7.
- Write burst at address 1, burstcount 3, one idle cycle between beats 1 and 2, byteenable 0011 -> reg_write_en pulses 0x02, 0x04, 0x08 on the three beat cycles, reg_byteenable 0011 on each; waitrequest stays 0.
- LATENCY=3, back-to-back single reads at addresses 0, 1, 2 on consecutive cycles -> strobes at t+2, t+3, t+4; read_valid at t+3, t+4, t+5 in order with matching data.
- reset_n low for 1 cycle during the 2nd beat of a 4-beat read burst -> outputs clear immediately, no further read_valid; a read issued after release at address 0 returns normally. A burstcount 0 command behaves as a single beat.
